netlist_vector_engine: RTL and testbench

Self-checking stimulus/response engine that sits on the opposite side of a mapped combinational netlist (14 primary inputs, 8 primary outputs). It drives pseudo-random input vectors from an LFSR into the netlist, compacts the returned outputs into a MISR signature, and compares the final signature with a golden value. It is used on the evaluation board to confirm that an optimized mapping is functionally equivalent to the original.

---
 rtl/netlist_vector_engine_pkg.sv | 22 ++
 rtl/netlist_vector_engine_if.sv | 30 +++
 rtl/nve_misr.sv | 32 +++
 rtl/netlist_vector_engine.sv | 109 ++++++++++
 tb/tb_netlist_vector_engine.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/netlist_vector_engine_pkg.sv
// Shared types and tap constants for the netlist vector engine:
// FSM states, LFSR/MISR feedback taps and the zero-seed substitute.
package nve_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam int unsigned LFSR_TAP0 = 13;
  localparam int unsigned LFSR_TAP1 = 12;
  localparam int unsigned LFSR_TAP2 = 11;
  localparam int unsigned LFSR_TAP3 = 1;
  localparam logic [13:0] LFSR_ZERO_SUB = 14'h0001;

  localparam int unsigned MISR_TAP0 = 15;
  localparam int unsigned MISR_TAP1 = 13;
  localparam int unsigned MISR_TAP2 = 12;
  localparam int unsigned MISR_TAP3 = 10;

endpackage

// File: rtl/netlist_vector_engine_if.sv
// Control, status and netlist-facing signals of the vector engine.
// The engine takes the slave side; board control and the netlist sit on master.
interface netlist_vector_engine_if #(
  parameter int unsigned NUM_IN  = 14,
  parameter int unsigned NUM_OUT = 8,
  parameter int unsigned SIG_W   = 16,
  parameter int unsigned CNT_W   = 16
);
  logic               start;
  logic               pause;
  logic [CNT_W-1:0]   num_vec;
  logic [NUM_IN-1:0]  seed;
  logic [SIG_W-1:0]   golden_sig;
  logic [NUM_IN-1:0]  dut_in;
  logic [NUM_OUT-1:0] dut_out;
  logic               busy;
  logic               done;
  logic               pass;
  logic [SIG_W-1:0]   sig;

  modport master (
    output start, pause, num_vec, seed, golden_sig, dut_out,
    input  dut_in, busy, done, pass, sig
  );

  modport slave (
    input  start, pause, num_vec, seed, golden_sig, dut_out,
    output dut_in, busy, done, pass, sig
  );
endinterface

// File: rtl/nve_misr.sv
// Multiple-input signature register: shifts left with tap feedback and
// XORs the data word in on every enabled cycle.
module nve_misr
  import nve_pkg::*;
#(
  parameter int unsigned SIG_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [SIG_W-1:0] din_i,
  output logic [SIG_W-1:0] sig_o
);

  logic [SIG_W-1:0] sig_q;
  logic             fb;

  assign fb    = sig_q[MISR_TAP0] ^ sig_q[MISR_TAP1] ^ sig_q[MISR_TAP2] ^ sig_q[MISR_TAP3];
  assign sig_o = sig_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= '0;
    end else if (clr_i) begin
      sig_q <= '0;
    end else if (en_i) begin
      sig_q <= {sig_q[SIG_W-2:0], fb} ^ din_i;
    end
  end

endmodule

// File: rtl/netlist_vector_engine.sv
// LFSR stimulus / MISR response engine for checking a mapped netlist
// against a golden signature.
module netlist_vector_engine
  import nve_pkg::*;
#(
  parameter int unsigned NUM_IN  = 14,
  parameter int unsigned NUM_OUT = 8,
  parameter int unsigned SIG_W   = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  netlist_vector_engine_if.slave  bus
);

  state_e             state_q, state_d;
  logic [NUM_IN-1:0]  lfsr_q, lfsr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   nvec_q, nvec_d;
  logic [SIG_W-1:0]   gold_q, gold_d;
  logic               pass_q, pass_d;
  logic               lfsr_fb;
  logic               misr_clr, misr_en;
  logic               done_c;
  logic               sig_match;
  logic [NUM_OUT-1:0] resp;
  logic [SIG_W-1:0]   sig;

  assign lfsr_fb   = lfsr_q[LFSR_TAP0] ^ lfsr_q[LFSR_TAP1] ^ lfsr_q[LFSR_TAP2] ^ lfsr_q[LFSR_TAP3];
  assign resp      = bus.dut_out;
  assign sig_match = (sig == gold_q);

  nve_misr #(.SIG_W(SIG_W)) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (misr_clr),
    .en_i  (misr_en),
    .din_i (SIG_W'(resp)),
    .sig_o (sig)
  );

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    cnt_d    = cnt_q;
    nvec_d   = nvec_q;
    gold_d   = gold_q;
    pass_d   = pass_q;
    misr_clr = 1'b0;
    misr_en  = 1'b0;
    done_c   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          nvec_d   = bus.num_vec;
          gold_d   = bus.golden_sig;
          lfsr_d   = (bus.seed == '0) ? NUM_IN'(LFSR_ZERO_SUB) : bus.seed;
          cnt_d    = '0;
          pass_d   = 1'b0;
          misr_clr = 1'b1;
          state_d  = (bus.num_vec == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (!bus.pause) begin
          misr_en = 1'b1;
          lfsr_d  = {lfsr_q[NUM_IN-2:0], lfsr_fb};
          cnt_d   = cnt_q + 1'b1;
          // cnt_d reaches nvec_q on the edge that absorbs the last vector
          if (cnt_d == nvec_q) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        done_c  = 1'b1;
        pass_d  = sig_match;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lfsr_q  <= '0;
      cnt_q   <= '0;
      nvec_q  <= '0;
      gold_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      nvec_q  <= nvec_d;
      gold_q  <= gold_d;
      pass_q  <= pass_d;
    end
  end

  assign bus.dut_in = lfsr_q;
  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = done_c;
  // pass is already valid during the done cycle, then held from pass_q
  assign bus.pass   = (state_q == DONE) ? sig_match : pass_q;
  assign bus.sig    = sig;

endmodule

// File: tb/tb_netlist_vector_engine.sv
// Directed-vector bench for netlist_vector_engine with a small behavioural
// netlist and signature model.
module tb_netlist_vector_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] mode = 2'd0;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  netlist_vector_engine_if #(.NUM_IN(14), .NUM_OUT(8), .SIG_W(16), .CNT_W(16)) bus ();

  netlist_vector_engine #(.NUM_IN(14), .NUM_OUT(8), .SIG_W(16), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [7:0] net(input logic [1:0] md, input logic [13:0] v);
    case (md)
      2'd0:    return 8'h00;
      2'd1:    return 8'h01;
      2'd2:    return 8'hFF;
      default: return {v[0], v[7:1]} ^ v[13:6];
    endcase
  endfunction

  always_comb bus.dut_out = net(mode, bus.dut_in);

  function automatic logic [15:0] model_sig(input logic [13:0] sd, input int unsigned nv,
                                            input logic [1:0] md);
    logic [13:0] s;
    logic [15:0] m;
    s = (sd == 14'd0) ? 14'h0001 : sd;
    m = 16'h0000;
    for (int unsigned k = 0; k < nv; k++) begin
      m = {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]} ^ {8'h00, net(md, s)};
      s = {s[12:0], s[13] ^ s[12] ^ s[11] ^ s[1]};
    end
    return m;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Leaves the bench at the negedge inside cycle E0+1.
  task automatic launch(input logic [13:0] sd, input logic [15:0] nv, input logic [15:0] gd);
    @(negedge clk);
    bus.start      = 1'b1;
    bus.seed       = sd;
    bus.num_vec    = nv;
    bus.golden_sig = gd;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int cyc0, input int limit, output int cyc);
    cyc = cyc0;
    while (!bus.done && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  typedef struct {
    logic [13:0] seed;
    logic [15:0] nv;
    logic [15:0] gold;
    logic [1:0]  md;
    logic [15:0] exp_sig;
    logic        exp_pass;
    int          exp_cyc;
  } vec_t;

  vec_t tv[7];
  int   cyc;
  logic [15:0] ref_sig;

  initial begin
    tv[0] = '{14'h0001, 16'd3, 16'h0000, 2'd0, 16'h0000, 1'b1, 4};
    tv[1] = '{14'h0000, 16'd2, 16'h0003, 2'd1, 16'h0003, 1'b1, 3};
    tv[2] = '{14'h0000, 16'd2, 16'h0004, 2'd1, 16'h0003, 1'b0, 3};
    tv[3] = '{14'h0155, 16'd0, 16'h0000, 2'd1, 16'h0000, 1'b1, 1};
    tv[4] = '{14'h0001, 16'd3, 16'h02FD, 2'd2, 16'h02FD, 1'b1, 4};
    tv[5] = '{14'h0001, 16'd3, 16'h0007, 2'd1, 16'h0007, 1'b1, 4};
    ref_sig = model_sig(14'h2AAA, 300, 2'd3);
    tv[6] = '{14'h2AAA, 16'd300, ref_sig, 2'd3, ref_sig, 1'b1, 301};

    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.num_vec = '0;
    bus.seed = '0;
    bus.golden_sig = '0;

    #12;
    chk("rst_dut_in", bus.dut_in, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_pass", bus.pass, 0);
    chk("rst_sig", bus.sig, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      mode = tv[i].md;
      launch(tv[i].seed, tv[i].nv, tv[i].gold);
      wait_done(1, int'(tv[i].nv) + 10, cyc);
      chk($sformatf("v%0d_done_cyc", i), cyc, tv[i].exp_cyc);
      chk($sformatf("v%0d_sig", i), bus.sig, tv[i].exp_sig);
      chk($sformatf("v%0d_pass", i), bus.pass, tv[i].exp_pass);
      chk($sformatf("v%0d_busy_at_done", i), bus.busy, 1);
      @(negedge clk);
      chk($sformatf("v%0d_busy_after", i), bus.busy, 0);
      chk($sformatf("v%0d_done_after", i), bus.done, 0);
      chk($sformatf("v%0d_pass_held", i), bus.pass, tv[i].exp_pass);
    end

    // LFSR sequence from seed 1
    mode = 2'd0;
    launch(14'h0001, 16'd3, 16'h0000);
    chk("seq_v0", bus.dut_in, 14'h0001);
    chk("seq_busy", bus.busy, 1);
    @(negedge clk);
    chk("seq_v1", bus.dut_in, 14'h0002);
    @(negedge clk);
    chk("seq_v2", bus.dut_in, 14'h0005);
    @(negedge clk);
    chk("seq_done", bus.done, 1);
    @(negedge clk);

    // pause for three cycles while vector 1 is presented
    mode = 2'd3;
    launch(14'h0001, 16'd4, model_sig(14'h0001, 4, 2'd3));
    chk("pause_v0", bus.dut_in, 14'h0001);
    @(negedge clk);
    chk("pause_v1", bus.dut_in, 14'h0002);
    bus.pause = 1'b1;
    for (int k = 3; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("pause_hold_c%0d", k), bus.dut_in, 14'h0002);
    end
    bus.pause = 1'b0;
    wait_done(5, 30, cyc);
    chk("pause_done_cyc", cyc, 8);
    chk("pause_sig", bus.sig, model_sig(14'h0001, 4, 2'd3));
    chk("pause_pass", bus.pass, 1);
    @(negedge clk);

    // pause on the final vector delays its absorption
    launch(14'h0001, 16'd2, 16'h0000);
    @(negedge clk);
    bus.pause = 1'b1;
    @(negedge clk);
    chk("plast_busy", bus.busy, 1);
    chk("plast_nodone", bus.done, 0);
    bus.pause = 1'b0;
    wait_done(3, 20, cyc);
    chk("plast_done_cyc", cyc, 4);
    chk("plast_sig", bus.sig, model_sig(14'h0001, 2, 2'd3));
    @(negedge clk);

    // start during RUN is ignored; original num_vec/golden stay latched
    launch(14'h0ABC, 16'd5, model_sig(14'h0ABC, 5, 2'd3));
    @(negedge clk);
    bus.start = 1'b1;
    bus.num_vec = 16'd2;
    bus.golden_sig = 16'h0000;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(3, 30, cyc);
    chk("restart_done_cyc", cyc, 6);
    chk("restart_sig", bus.sig, model_sig(14'h0ABC, 5, 2'd3));
    chk("restart_pass", bus.pass, 1);
    @(negedge clk);

    // asynchronous reset mid-run, then a clean rerun
    launch(14'h1234, 16'd100, 16'h0000);
    repeat (40) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_dut_in", bus.dut_in, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_done", bus.done, 0);
    chk("arst_pass", bus.pass, 0);
    chk("arst_sig", bus.sig, 0);
    @(negedge clk);
    rst_n = 1'b1;
    launch(14'h1234, 16'd100, model_sig(14'h1234, 100, 2'd3));
    wait_done(1, 200, cyc);
    chk("rerun_done_cyc", cyc, 101);
    chk("rerun_sig", bus.sig, model_sig(14'h1234, 100, 2'd3));
    chk("rerun_pass", bus.pass, 1);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
